// File: rtl/usbh_report_arbiter.sv
// usbh_report_arbiter
// Shares one HID report decoder between two USB host ports. The latest report
// per port is buffered and issued round-robin to the decoder. The decoded NES
// button byte is captured after a fixed latency and routed to the owning
// player's register. A port that stops reporting is cleared after a timeout.
module usbh_report_arbiter #(
  parameter int c_clk_hz         = 6000000,
  parameter int c_timeout_ms     = 100,
  parameter int c_decode_latency = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_report0,
  input  logic        i_report0_valid,
  input  logic [63:0] i_report1,
  input  logic        i_report1_valid,
  output logic [63:0] o_dec_report,
  output logic        o_dec_report_valid,
  input  logic [7:0]  i_dec_btn,
  output logic [7:0]  o_btn0,
  output logic [7:0]  o_btn1,
  output logic [1:0]  o_conn,
  output logic [1:0]  o_overrun
);

  localparam int c_div   = c_clk_hz / 1000;
  localparam int c_pre_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_ms_w  = $clog2(c_timeout_ms + 1);
  localparam int c_lat_w = $clog2(c_decode_latency + 1);

  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_div - 1);
  localparam logic [c_ms_w-1:0]  c_ms_last  = c_ms_w'(c_timeout_ms - 1);
  localparam logic [c_ms_w-1:0]  c_ms_max   = c_ms_w'(c_timeout_ms);
  localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(c_decode_latency - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [1:0][63:0]        buf_q;
  logic [1:0]              pend_q, pend_d;
  logic [1:0]              overrun_q, overrun_d;
  logic                    last_q;
  logic                    gnt_q;
  logic [c_lat_w-1:0]      lat_q;
  logic [63:0]             dec_report_q;
  logic                    dec_valid_q;
  logic [1:0][7:0]         btn_q;
  logic [1:0]              conn_q;
  logic [c_pre_w-1:0]      pre_q;
  logic [1:0][c_ms_w-1:0]  ms_q;

  logic [1:0]  valid_s;
  logic        issue_s;
  logic        gnt_s;
  logic        tick_s;
  logic [1:0]  cap_s;
  logic [1:0]  to_s;

  assign valid_s = {i_report1_valid, i_report0_valid};

  // Grant selection, pending/overrun next state, timeout and capture events.
  always_comb begin
    issue_s = (state_q == ST_IDLE) && (pend_q != 2'b00);
    if (pend_q == 2'b01) begin
      gnt_s = 1'b0;
    end else if (pend_q == 2'b10) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = ~last_q;
    end
    tick_s = (pre_q == c_pre_last);
    for (int n = 0; n < 2; n++) begin
      // A strobe in the issue cycle re-arms pend; the issued copy is already
      // snapshotted, so that case is not an overwrite.
      if (issue_s && (gnt_s == n[0])) begin
        pend_d[n]    = valid_s[n];
        overrun_d[n] = 1'b0;
      end else begin
        pend_d[n]    = valid_s[n] | pend_q[n];
        overrun_d[n] = valid_s[n] & pend_q[n];
      end
      cap_s[n] = (state_q == ST_CAPTURE) && (gnt_q == n[0]);
      to_s[n]  = tick_s && (ms_q[n] == c_ms_last) && !valid_s[n];
    end
  end

  // Report buffers, pending flags and overrun pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q     <= '0;
      pend_q    <= 2'b00;
      overrun_q <= 2'b00;
    end else begin
      if (i_report0_valid) buf_q[0] <= i_report0;
      if (i_report1_valid) buf_q[1] <= i_report1;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  // Issue / wait / capture sequencer driving the shared decoder.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      lat_q        <= '0;
      dec_report_q <= 64'd0;
      dec_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            dec_report_q <= buf_q[gnt_s];
            dec_valid_q  <= 1'b1;
            gnt_q        <= gnt_s;
            last_q       <= gnt_s;
            state_q      <= ST_ISSUE;
          end else begin
            dec_valid_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          dec_valid_q <= 1'b0;
          lat_q       <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          dec_valid_q <= 1'b0;
          if (lat_q == c_lat_last) begin
            state_q <= ST_CAPTURE;
          end else begin
            lat_q <= lat_q + c_lat_w'(1);
          end
        end
        ST_CAPTURE: begin
          dec_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          dec_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Shared millisecond prescaler, free running and wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q <= '0;
    end else if (tick_s) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + c_pre_w'(1);
    end
  end

  // Per-port silence counters and button/connect registers; capture beats timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ms_q   <= '0;
      btn_q  <= '0;
      conn_q <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (valid_s[n] || cap_s[n]) begin
          ms_q[n] <= '0;
        end else if (tick_s && (ms_q[n] != c_ms_max)) begin
          ms_q[n] <= ms_q[n] + c_ms_w'(1);
        end
        if (cap_s[n]) begin
          btn_q[n]  <= i_dec_btn;
          conn_q[n] <= 1'b1;
        end else if (to_s[n]) begin
          btn_q[n]  <= 8'd0;
          conn_q[n] <= 1'b0;
        end
      end
    end
  end

  assign o_dec_report       = dec_report_q;
  assign o_dec_report_valid = dec_valid_q;
  assign o_btn0             = btn_q[0];
  assign o_btn1             = btn_q[1];
  assign o_conn             = conn_q;
  assign o_overrun          = overrun_q;

endmodule
